// File: rtl/divider_binary_unsigned_if.sv
// Start/done handshake bundle for the iterative unsigned divider.
// The requester drives start and the operands. The divider returns
// busy, done and the registered results.
interface divider_binary_unsigned_if #(
   parameter int unsigned DW = 4,
   parameter int unsigned VW = 2
);
   logic          start;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          busy;
   logic          done;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_zero
   );
endinterface

// File: rtl/divider_binary_unsigned.sv
// Iterative restoring divider for unsigned operands.
// It resolves one quotient bit per cycle, starting at the MSB. The result is
// ready DW+1 cycles after start: done pulses for one cycle, and the
// quotient, remainder and div_zero registers hold until the next done.
module divider_binary_unsigned #(
   parameter int unsigned DW = 4,
   parameter int unsigned VW = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   divider_binary_unsigned_if.slave bus
);

   localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t        state;
   logic [DW-1:0] d_reg;
   logic [DW-1:0] q_reg;
   logic [VW-1:0] v_reg;
   // The partial remainder never reaches the divisor after a step.
   // VW bits are therefore enough to hold it between steps. Only the trial
   // value needs the extra bit.
   logic [VW-1:0] r_reg;
   logic [CW-1:0] count;

   logic [VW:0]   trial;
   logic          fit;
   logic [VW-1:0] r_next;
   logic [DW-1:0] q_next;

   // One restoring step: bring in the next dividend bit and subtract if it fits
   always_comb begin
      trial  = {r_reg, d_reg[DW-1]};
      fit    = (trial >= {1'b0, v_reg});
      r_next = trial[VW-1:0];
      if (fit) begin
         // The true difference is below the divisor, so modulo-2^VW arithmetic is exact.
         r_next = trial[VW-1:0] - v_reg;
      end
      q_next = {q_reg[DW-2:0], fit};
   end

   // Control FSM and datapath registers, including the registered result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         d_reg         <= '0;
         q_reg         <= '0;
         v_reg         <= '0;
         r_reg         <= '0;
         count         <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.quotient  <= '0;
         bus.remainder <= '0;
         bus.div_zero  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  d_reg    <= bus.dividend;
                  v_reg    <= bus.divisor;
                  r_reg    <= '0;
                  q_reg    <= '0;
                  count    <= CW'(DW - 1);
                  bus.busy <= 1'b1;
                  state    <= CALC;
               end
            end
            CALC: begin
               r_reg <= r_next;
               q_reg <= q_next;
               d_reg <= {d_reg[DW-2:0], 1'b0};
               if (count == '0) begin
                  // Results are registered on entry to DONE.
                  // This makes them valid during the same cycle as the done pulse.
                  state    <= DONE;
                  bus.done <= 1'b1;
                  if (v_reg == '0) begin
                     bus.quotient  <= '1;
                     bus.remainder <= '0;
                     bus.div_zero  <= 1'b1;
                  end else begin
                     bus.quotient  <= q_next;
                     bus.remainder <= r_next;
                     bus.div_zero  <= 1'b0;
                  end
               end else begin
                  count <= count - 1'b1;
               end
            end
            DONE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divider_binary_unsigned.sv
// Self-checking bench for divider_binary_unsigned.
// Two instances are exercised: the default 4/2 configuration and a wider
// 8/4 configuration. Expected results are queued when each start is driven
// and popped when done appears.
`timescale 1ns/1ps
module tb_divider_binary_unsigned;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   divider_binary_unsigned_if #(.DW(4), .VW(2)) bus_n ();
   divider_binary_unsigned_if #(.DW(8), .VW(4)) bus_w ();

   divider_binary_unsigned #(.DW(4), .VW(2)) dut_n (
      .clk (clk),
      .rst (rst),
      .bus (bus_n.slave)
   );

   divider_binary_unsigned #(.DW(8), .VW(4)) dut_w (
      .clk (clk),
      .rst (rst),
      .bus (bus_w.slave)
   );

   typedef struct packed {
      logic [3:0] q;
      logic [1:0] r;
      logic       z;
   } exp_n_t;

   typedef struct packed {
      logic [7:0] q;
      logic [3:0] r;
      logic       z;
   } exp_w_t;

   exp_n_t sb_n[$];
   exp_w_t sb_w[$];
   int vectors = 0;
   int miscompares = 0;
   localparam int LIMIT = 20;

   function automatic exp_n_t model_n(input logic [3:0] a, input logic [1:0] b);
      exp_n_t e;
      if (b == 2'd0) begin
         e.q = 4'hF; e.r = 2'd0; e.z = 1'b1;
      end else begin
         e.q = a / b; e.r = 2'(a % b); e.z = 1'b0;
      end
      return e;
   endfunction

   function automatic exp_w_t model_w(input logic [7:0] a, input logic [3:0] b);
      exp_w_t e;
      if (b == 4'd0) begin
         e.q = 8'hFF; e.r = 4'd0; e.z = 1'b1;
      end else begin
         e.q = a / b; e.r = 4'(a % b); e.z = 1'b0;
      end
      return e;
   endfunction

   // Drive a request at the current negedge and queue its expected result
   task automatic issue_n(input logic [3:0] a, input logic [1:0] b);
      bus_n.start    = 1'b1;
      bus_n.dividend = a;
      bus_n.divisor  = b;
      sb_n.push_back(model_n(a, b));
   endtask

   task automatic issue_w(input logic [7:0] a, input logic [3:0] b);
      bus_w.start    = 1'b1;
      bus_w.dividend = a;
      bus_w.divisor  = b;
      sb_w.push_back(model_w(a, b));
   endtask

   task automatic wait_done_n(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         bus_n.start = 1'b0;
      end while (!bus_n.done && lat < LIMIT);
   endtask

   task automatic wait_done_w(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         bus_w.start = 1'b0;
      end while (!bus_w.done && lat < LIMIT);
   endtask

   task automatic test_reset();
      exp_n_t e;
      int lat;
      rst = 1'b1;
      bus_n.start = 1'b1; bus_n.dividend = 4'd9; bus_n.divisor = 2'd3;
      repeat (2) begin
         @(negedge clk);
         vectors++;
         if ({bus_n.busy, bus_n.done, bus_n.quotient, bus_n.remainder, bus_n.div_zero} !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got busy=%b done=%b q=%0d r=%0d z=%b want all 0",
                     bus_n.busy, bus_n.done, bus_n.quotient, bus_n.remainder, bus_n.div_zero);
         end
      end
      rst = 1'b0;
      issue_n(4'd9, 2'd3);
      wait_done_n(lat);
      e = sb_n.pop_front();
      vectors++;
      if (lat !== 5) begin
         miscompares++; $display("FAIL reset_latency got %0d want 5", lat);
      end
      vectors++;
      if ({bus_n.quotient, bus_n.remainder, bus_n.div_zero} !== {4'd3, 2'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_9div3 got q=%0d r=%0d z=%b want q=3 r=0 z=0",
                  bus_n.quotient, bus_n.remainder, bus_n.div_zero);
      end
      @(negedge clk);
      vectors++;
      if (bus_n.done !== 1'b0) begin
         miscompares++; $display("FAIL reset_done_width got done=%b want 0", bus_n.done);
      end
   endtask

   task automatic test_normal();
      logic [3:0] ta [4] = '{4'd15, 4'd0, 4'd14, 4'd1};
      logic [1:0] tb [4] = '{2'd2, 2'd3, 2'd3, 2'd3};
      logic [6:0] want [4] = '{{4'd7, 2'd1, 1'b0}, {4'd0, 2'd0, 1'b0},
                               {4'd4, 2'd2, 1'b0}, {4'd0, 2'd1, 1'b0}};
      exp_n_t e;
      int lat;
      for (int i = 0; i < 4; i++) begin
         issue_n(ta[i], tb[i]);
         wait_done_n(lat);
         e = sb_n.pop_front();
         vectors++;
         if (lat !== 5) begin
            miscompares++; $display("FAIL normal_latency[%0d] got %0d want 5", i, lat);
         end
         vectors++;
         if ({bus_n.quotient, bus_n.remainder, bus_n.div_zero} !== want[i] || want[i] !== e) begin
            miscompares++;
            $display("FAIL normal_result %0d/%0d got q=%0d r=%0d z=%b want q=%0d r=%0d",
                     ta[i], tb[i], bus_n.quotient, bus_n.remainder, bus_n.div_zero,
                     want[i][6:3], want[i][2:1]);
         end
         @(negedge clk);
         vectors++;
         if (bus_n.done !== 1'b0) begin
            miscompares++; $display("FAIL normal_done_width[%0d] got done=%b want 0", i, bus_n.done);
         end
      end
   endtask

   task automatic test_div_zero();
      logic [3:0] ta [2] = '{4'd5, 4'd6};
      logic [1:0] tb [2] = '{2'd0, 2'd2};
      logic [6:0] want [2] = '{{4'hF, 2'd0, 1'b1}, {4'd3, 2'd0, 1'b0}};
      exp_n_t e;
      int lat;
      for (int i = 0; i < 2; i++) begin
         issue_n(ta[i], tb[i]);
         wait_done_n(lat);
         e = sb_n.pop_front();
         vectors++;
         if (lat !== 5) begin
            miscompares++; $display("FAIL divzero_latency[%0d] got %0d want 5", i, lat);
         end
         vectors++;
         if ({bus_n.quotient, bus_n.remainder, bus_n.div_zero} !== e) begin
            miscompares++;
            $display("FAIL divzero_result %0d/%0d got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                     ta[i], tb[i], bus_n.quotient, bus_n.remainder, bus_n.div_zero,
                     want[i][6:3], want[i][2:1], want[i][0]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_handshake();
      exp_n_t e;
      logic [6:0] prev;
      int lat;
      int dones;
      prev = {bus_n.quotient, bus_n.remainder, bus_n.div_zero};
      issue_n(4'd12, 2'd3);
      lat = 0;
      dones = 0;
      do begin
         @(negedge clk);
         lat++;
         bus_n.start = (lat == 2);
         if (lat == 2) begin
            bus_n.dividend = 4'd7; bus_n.divisor = 2'd1;
         end
         if (bus_n.done) begin
            dones++;
         end else if (lat > 1) begin
            vectors++;
            if ({bus_n.quotient, bus_n.remainder, bus_n.div_zero} !== prev) begin
               miscompares++;
               $display("FAIL hold_during_calc got %h want %h", {bus_n.quotient, bus_n.remainder, bus_n.div_zero}, prev);
            end
         end
      end while (!bus_n.done && lat < LIMIT);
      e = sb_n.pop_front();
      vectors++;
      if (lat !== 5 || dones !== 1) begin
         miscompares++; $display("FAIL busy_start_latency got %0d dones=%0d want 5 dones=1", lat, dones);
      end
      vectors++;
      if ({bus_n.quotient, bus_n.remainder, bus_n.div_zero} !== e || e !== {4'd4, 2'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL busy_start_result got q=%0d r=%0d want q=4 r=0", bus_n.quotient, bus_n.remainder);
      end
      // start held from the done cycle: ignored there, accepted the cycle after
      issue_n(4'd6, 2'd3);
      @(negedge clk);
      vectors++;
      if (bus_n.busy !== 1'b0 || bus_n.done !== 1'b0) begin
         miscompares++;
         $display("FAIL done_cycle_start got busy=%b done=%b want busy=0 done=0", bus_n.busy, bus_n.done);
      end
      wait_done_n(lat);
      e = sb_n.pop_front();
      vectors++;
      if (lat !== 5) begin
         miscompares++; $display("FAIL back_to_back_latency got %0d want 5", lat);
      end
      vectors++;
      if ({bus_n.quotient, bus_n.remainder, bus_n.div_zero} !== e) begin
         miscompares++;
         $display("FAIL back_to_back_result got q=%0d r=%0d want q=%0d r=%0d",
                  bus_n.quotient, bus_n.remainder, e.q, e.r);
      end
      @(negedge clk);
   endtask

   task automatic test_mid_reset();
      exp_n_t e;
      int lat;
      int dones;
      issue_n(4'd15, 2'd1);
      @(negedge clk);
      bus_n.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      void'(sb_n.pop_back());
      dones = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus_n.done) dones++;
      end
      vectors++;
      if (dones !== 0) begin
         miscompares++; $display("FAIL abort_no_done got %0d done pulses want 0", dones);
      end
      vectors++;
      if ({bus_n.busy, bus_n.quotient, bus_n.remainder, bus_n.div_zero} !== 8'd0) begin
         miscompares++;
         $display("FAIL abort_outputs got busy=%b q=%0d r=%0d z=%b want all 0",
                  bus_n.busy, bus_n.quotient, bus_n.remainder, bus_n.div_zero);
      end
      issue_n(4'd10, 2'd3);
      wait_done_n(lat);
      e = sb_n.pop_front();
      vectors++;
      if (lat !== 5 || {bus_n.quotient, bus_n.remainder, bus_n.div_zero} !== {4'd3, 2'd1, 1'b0}) begin
         miscompares++;
         $display("FAIL after_abort got lat=%0d q=%0d r=%0d want lat=5 q=3 r=1", lat, bus_n.quotient, bus_n.remainder);
      end
      @(negedge clk);
   endtask

   task automatic test_mult_inverse();
      exp_n_t e;
      int lat;
      for (int a = 0; a < 4; a++) begin
         for (int b = 1; b < 4; b++) begin
            issue_n(4'(a * b), 2'(b));
            wait_done_n(lat);
            e = sb_n.pop_front();
            vectors++;
            if (lat !== 5 || bus_n.quotient !== 4'(a) || bus_n.remainder !== 2'd0 || bus_n.div_zero !== 1'b0) begin
               miscompares++;
               $display("FAIL mult_inverse %0d*%0d/%0d got lat=%0d q=%0d r=%0d want lat=5 q=%0d r=0",
                        a, b, b, lat, bus_n.quotient, bus_n.remainder, a);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_exhaustive();
      exp_n_t e;
      int lat;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 4; b++) begin
            issue_n(4'(a), 2'(b));
            wait_done_n(lat);
            e = sb_n.pop_front();
            vectors++;
            if (lat !== 5 || {bus_n.quotient, bus_n.remainder, bus_n.div_zero} !== e) begin
               miscompares++;
               $display("FAIL exhaustive %0d/%0d got lat=%0d q=%0d r=%0d z=%b want lat=5 q=%0d r=%0d z=%b",
                        a, b, lat, bus_n.quotient, bus_n.remainder, bus_n.div_zero, e.q, e.r, e.z);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_wide();
      exp_w_t e;
      int lat;
      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 16; b++) begin
            issue_w(8'(a), 4'(b));
            wait_done_w(lat);
            e = sb_w.pop_front();
            vectors++;
            if (lat !== 9 || {bus_w.quotient, bus_w.remainder, bus_w.div_zero} !== e) begin
               miscompares++;
               $display("FAIL wide %0d/%0d got lat=%0d q=%0d r=%0d z=%b want lat=9 q=%0d r=%0d z=%b",
                        a, b, lat, bus_w.quotient, bus_w.remainder, bus_w.div_zero, e.q, e.r, e.z);
            end
            @(negedge clk);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      bus_n.start = 1'b0; bus_n.dividend = '0; bus_n.divisor = '0;
      bus_w.start = 1'b0; bus_w.dividend = '0; bus_w.divisor = '0;
      test_reset();
      test_normal();
      test_div_zero();
      test_handshake();
      test_mid_reset();
      test_mult_inverse();
      test_exhaustive();
      test_wide();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
